// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the unified instruction/data memory port.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Loadable down-counter that times one fixed-latency memory access.
module mem_lat_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port memory between fetch (IF) and data (DM) stages;
// DM has fixed priority and each access holds the port for MEM_LAT cycles.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = mem_port_arbiter_pkg::ADDR_W,
    parameter int unsigned DATA_W  = mem_port_arbiter_pkg::DATA_W,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

    state_e            state, state_d;
    owner_e            owner, owner_d;
    logic              kill, kill_d;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic              if_elig, dm_elig;
    logic [DATA_W-1:0] if_rdata_d, dm_rdata_d, mem_wdata_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic              if_valid_d, dm_valid_d, mem_en_d, mem_we_d;

    // A requester whose valid is pulsing now is finished, so its held req is stale.
    assign if_elig  = if_req & ~if_flush & ~if_valid;
    assign dm_elig  = dm_req & ~dm_valid;
    assign if_stall = if_req & ~if_valid & ~if_flush;
    assign dm_stall = dm_req & ~dm_valid;

    mem_lat_counter #(
        .W (CNT_W)
    ) u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CNT_W'(MEM_LAT - 1)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Next-state and next-output logic; mem_addr/mem_we/mem_wdata double as the latched request.
    always_comb begin
        state_d     = state;
        owner_d     = owner;
        kill_d      = kill;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        if_rdata_d  = if_rdata;
        dm_rdata_d  = dm_rdata;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        mem_en_d    = mem_en;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;

        case (state)
            ST_IDLE: begin
                if (dm_elig) begin
                    owner_d     = OWN_DM;
                    mem_addr_d  = dm_addr;
                    mem_we_d    = dm_we;
                    mem_wdata_d = dm_wdata;
                    mem_en_d    = 1'b1;
                    cnt_load    = 1'b1;
                    state_d     = ST_ACCESS;
                end else if (if_elig) begin
                    owner_d     = OWN_IF;
                    mem_addr_d  = if_addr;
                    mem_we_d    = 1'b0;
                    mem_wdata_d = '0;
                    mem_en_d    = 1'b1;
                    cnt_load    = 1'b1;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if ((owner == OWN_IF) && if_flush) begin
                    kill_d = 1'b1;
                end
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                    kill_d   = 1'b0;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (owner == OWN_DM) begin
                        dm_valid_d = 1'b1;
                        if (!mem_we) begin
                            dm_rdata_d = mem_rdata;
                        end
                    end else if (!kill && !if_flush) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            owner     <= OWN_IF;
            kill      <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_d;
            owner     <= owner_d;
            kill      <= kill_d;
            if_rdata  <= if_rdata_d;
            dm_rdata  <= dm_rdata_d;
            if_valid  <= if_valid_d;
            dm_valid  <= dm_valid_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single-port unified instruction/data memory between the fetch stage (IF) and the memory stage (DM).
- Sequences each fixed-latency memory access through a small FSM.
- Raises per-stage stall signals so the pipeline freezes until its access completes.
- Sits between the pipeline stages and the memory instance inside the processor top level.

Parameters:
- ADDR_W, 20, memory word-address width.
- DATA_W, 16, memory data width.
- MEM_LAT, 2, memory read latency in cycles; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held stable until if_valid or flush.
- if_addr  in  ADDR_W  fetch address.
- if_flush  in  1  cancels the pending or in-flight fetch (branch taken).
- if_rdata  out  DATA_W  fetched instruction word.
- if_valid  out  1  one-cycle pulse: if_rdata is valid.
- if_stall  out  1  fetch stage must hold.
- dm_req  in  1  data request; held stable until dm_valid.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_rdata  out  DATA_W  read data.
- dm_valid  out  1  one-cycle pulse: access done (read or write).
- dm_stall  out  1  memory stage must hold.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en rises.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0, owner=IF, latched addr/we/wdata=0.
  - if_rdata=0, dm_rdata=0, if_valid=0, dm_valid=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- States IDLE and ACCESS. All outputs are registered except if_stall and dm_stall.
- IDLE:
  - Eligible requests are if_req & ~if_flush & ~if_valid and dm_req & ~dm_valid. A requester whose valid is high this cycle is ignored, so a stale req is never re-granted.
  - DM has fixed priority over IF (the older instruction wins).
  - On grant: latch owner, addr, we (0 for IF), and wdata. Set cnt=MEM_LAT-1 and go to ACCESS.
- ACCESS:
  - mem_en=1; mem_addr, mem_we and mem_wdata come from the latched values, stable for all MEM_LAT cycles.
  - If cnt!=0, decrement.
  - If cnt==0, go to IDLE:
    - owner DM: dm_valid<=1 next cycle; on a read, dm_rdata<=mem_rdata; on a write, dm_rdata is unchanged.
    - owner IF: if_rdata<=mem_rdata and if_valid<=1, unless the fetch was flushed.
- Latency: grant at cycle 0, ACCESS for cycles 1..MEM_LAT, valid pulse at cycle MEM_LAT+1.
- A new grant may be made in the valid cycle, so peak throughput is one access per MEM_LAT+1 cycles.
- Flush:
  - if_flush while IF owns ACCESS sets a sticky kill bit. The memory access runs to completion, no if_valid is produced, and the kill bit clears on return to IDLE.
  - if_flush in IDLE suppresses the IF grant that cycle only.
  - if_flush never affects a DM access.
- Stalls (combinational):
  - if_stall = if_req & ~if_valid & ~if_flush.
  - dm_stall = dm_req & ~dm_valid.
- IF starvation is bounded because DM issues at most one access per instruction; no additional fairness mechanism exists.
- rst asserted mid-ACCESS aborts the access. No valid pulse follows, and the memory may see a partial access.
- Write data is committed by the memory on every ACCESS cycle; repeated writes of the same data to the same address are harmless.
- Simultaneous if_req and dm_req in IDLE: DM is granted, and IF is granted in the cycle dm_valid pulses (if still requested).

Decomposition:
- Shared header/package:
  - state encodings ST_IDLE and ST_ACCESS.
  - owner encodings OWN_IF and OWN_DM.
  - default widths ADDR_W and DATA_W, also used by the processor top and the memory.
- Optional single sub-module mem_lat_counter: loadable down-counter of width $clog2(MEM_LAT+1) with a zero flag.
- Otherwise one flat module.

Test Plan (MEM_LAT=2; the bench memory models 2-cycle latency with mem[5]=16'hA5A5 and mem[9]=16'h1234):
- Reset: drive rst=0 mid-run -> every output 0 immediately, with no clk edge required; release -> IDLE, no valid pulses.
- Single fetch: if_req=1, if_addr=5 at cycle 0 -> mem_en=1 with mem_addr=5 for cycles 1-2; if_valid=1 and if_rdata=16'hA5A5 at cycle 3; if_stall=1 for cycles 0-2 and 0 at cycle 3.
- Contention: if_req(addr 5) and dm_req(read, addr 9) at cycle 0 -> dm_valid with dm_rdata=16'h1234 at cycle 3; IF granted at cycle 3; if_valid with 16'hA5A5 at cycle 6; if_stall high for cycles 0-5.
- Write then read: dm_we=1, addr 9, wdata 16'hBEEF -> mem_we=1 for cycles 1-2, dm_valid at cycle 3, dm_rdata unchanged; a following read of addr 9 returns 16'hBEEF.
- Flush in flight: fetch addr 5 granted at cycle 0, if_flush=1 at cycle 1 -> no if_valid at cycle 3, if_rdata retains its old value, and a new fetch is granted no earlier than cycle 3.
- Reset mid-access: rst=0 at cycle 1 of a DM read -> mem_en=0 at once; after release, no dm_valid appears.
